// File: rtl/conv_fixew_pkg.sv
// Shared constants for the conv_fixew systolic convolution engine.
// Everything that sizes the datapath or the tap chain lives here.
package conv_fixew_pkg;

  localparam int DATA_W = 32;
  localparam int TAPS   = 9;

endpackage : conv_fixew_pkg

// File: rtl/conv_fixew_pe.sv
// One multiply-accumulate cell of the systolic chain.
// It registers psum_in + feature*weight, keeping only the low N bits.
module conv_pe
  import conv_fixew_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic                clk,
  input  logic                srst,
  input  logic signed [N-1:0] feature,
  input  logic signed [N-1:0] weight,
  input  logic signed [N-1:0] psum_in,
  output logic signed [N-1:0] psum_out
);

  logic signed [N-1:0] product;
  logic signed [N-1:0] psum_next;
  logic signed [N-1:0] psum_reg;

  // The product and the sum are both N bits wide, so results wrap modulo 2^N.
  assign product   = feature * weight;
  assign psum_next = psum_in + product;

  always_ff @(posedge clk) begin
    if (srst) begin
      psum_reg <= '0;
    end else begin
      psum_reg <= psum_next;
    end
  end

  assign psum_out = psum_reg;

endmodule : conv_pe

// File: rtl/conv_fixew.sv
// Two-channel, nine-tap systolic convolution engine.
// Both channels share the pre-skewed feature taps; each has its own weight set.
module conv_fixew
  import conv_fixew_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic signed [N-1:0] F1,
  input  logic signed [N-1:0] F2,
  input  logic signed [N-1:0] F3,
  input  logic signed [N-1:0] F4,
  input  logic signed [N-1:0] F5,
  input  logic signed [N-1:0] F6,
  input  logic signed [N-1:0] F7,
  input  logic signed [N-1:0] F8,
  input  logic signed [N-1:0] F9,
  input  logic signed [N-1:0] W00,
  input  logic signed [N-1:0] W01,
  input  logic signed [N-1:0] W02,
  input  logic signed [N-1:0] W03,
  input  logic signed [N-1:0] W10,
  input  logic signed [N-1:0] W11,
  input  logic signed [N-1:0] W12,
  input  logic signed [N-1:0] W13,
  input  logic signed [N-1:0] W14,
  input  logic signed [N-1:0] G00,
  input  logic signed [N-1:0] G01,
  input  logic signed [N-1:0] G02,
  input  logic signed [N-1:0] G03,
  input  logic signed [N-1:0] G10,
  input  logic signed [N-1:0] G11,
  input  logic signed [N-1:0] G12,
  input  logic signed [N-1:0] G13,
  input  logic signed [N-1:0] G14,
  output logic signed [N-1:0] C1,
  output logic signed [N-1:0] C2
);

  // Rst_n is active-high despite its name.
  logic srst;
  assign srst = Rst_n;

  logic signed [N-1:0] feature [TAPS];
  logic signed [N-1:0] w_set   [TAPS];
  logic signed [N-1:0] g_set   [TAPS];

  assign feature[0] = F1;
  assign feature[1] = F2;
  assign feature[2] = F3;
  assign feature[3] = F4;
  assign feature[4] = F5;
  assign feature[5] = F6;
  assign feature[6] = F7;
  assign feature[7] = F8;
  assign feature[8] = F9;

  assign w_set[0] = W00;
  assign w_set[1] = W01;
  assign w_set[2] = W02;
  assign w_set[3] = W03;
  assign w_set[4] = W10;
  assign w_set[5] = W11;
  assign w_set[6] = W12;
  assign w_set[7] = W13;
  assign w_set[8] = W14;

  assign g_set[0] = G00;
  assign g_set[1] = G01;
  assign g_set[2] = G02;
  assign g_set[3] = G03;
  assign g_set[4] = G10;
  assign g_set[5] = G11;
  assign g_set[6] = G12;
  assign g_set[7] = G13;
  assign g_set[8] = G14;

  // Entry 0 seeds the first cell with zero; entry TAPS is the last cell's register.
  logic signed [N-1:0] chain_c1 [TAPS+1];
  logic signed [N-1:0] chain_c2 [TAPS+1];

  assign chain_c1[0] = '0;
  assign chain_c2[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      conv_pe #(.N(N)) u_pe_c1 (
        .clk      (Clk),
        .srst     (srst),
        .feature  (feature[gi]),
        .weight   (w_set[gi]),
        .psum_in  (chain_c1[gi]),
        .psum_out (chain_c1[gi+1])
      );

      conv_pe #(.N(N)) u_pe_c2 (
        .clk      (Clk),
        .srst     (srst),
        .feature  (feature[gi]),
        .weight   (g_set[gi]),
        .psum_in  (chain_c2[gi]),
        .psum_out (chain_c2[gi+1])
      );
    end
  endgenerate

  assign C1 = chain_c1[TAPS];
  assign C2 = chain_c2[TAPS];

endmodule : conv_fixew

// File: tb/tb_conv_fixew.sv
// Directed bench for conv_fixew: reset, skewed vectors, impulse, signed data,
// modular wrap and a reset pulse in a steady stream, with hand-computed results.
module tb_conv_fixew;

  logic Clk;
  logic Rst_n;
  logic signed [31:0] f [9];
  logic signed [31:0] w [9];
  logic signed [31:0] g [9];
  logic signed [31:0] vec [9];
  logic signed [31:0] C1;
  logic signed [31:0] C2;

  int n_checks;
  int n_fail;

  conv_fixew #(.N(32)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .F1 (f[0]), .F2 (f[1]), .F3 (f[2]), .F4 (f[3]), .F5 (f[4]),
    .F6 (f[5]), .F7 (f[6]), .F8 (f[7]), .F9 (f[8]),
    .W00 (w[0]), .W01 (w[1]), .W02 (w[2]), .W03 (w[3]), .W10 (w[4]),
    .W11 (w[5]), .W12 (w[6]), .W13 (w[7]), .W14 (w[8]),
    .G00 (g[0]), .G01 (g[1]), .G02 (g[2]), .G03 (g[3]), .G10 (g[4]),
    .G11 (g[5]), .G12 (g[6]), .G13 (g[7]), .G14 (g[8]),
    .C1 (C1),
    .C2 (C2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
               tag, $signed(obs), obs, $signed(exp), exp);
    end else begin
      $display("ok   %s: %0d (0x%08h)", tag, $signed(obs), obs);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_f_all(input logic signed [31:0] v);
    for (int k = 0; k < 9; k++) f[k] = v;
  endtask

  task automatic set_w_all(input logic signed [31:0] v);
    for (int k = 0; k < 9; k++) w[k] = v;
  endtask

  task automatic set_g_all(input logic signed [31:0] v);
    for (int k = 0; k < 9; k++) g[k] = v;
  endtask

  task automatic flush(input string tag);
    set_f_all(0);
    for (int i = 0; i < 10; i++) tick();
    check({tag, "_flush_c1"}, C1, 32'd0);
    check({tag, "_flush_c2"}, C2, 32'd0);
  endtask

  // Presents vec[k] on tap k at edge e+k only; checks edges e+7, e+8, e+9.
  task automatic run_skew(input string tag, input logic [31:0] exp1, input logic [31:0] exp2);
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 9; k++) f[k] = (c == k) ? vec[k] : 32'sd0;
      tick();
      if (c == 7) begin
        check({tag, "_before_c1"}, C1, 32'd0);
        check({tag, "_before_c2"}, C2, 32'd0);
      end else if (c == 8) begin
        check({tag, "_c1"}, C1, exp1);
        check({tag, "_c2"}, C2, exp2);
      end else if (c == 9) begin
        check({tag, "_after_c1"}, C1, 32'd0);
        check({tag, "_after_c2"}, C2, 32'd0);
      end
    end
    set_f_all(0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset held for two edges with live inputs.
    Rst_n = 1'b1;
    set_f_all(5);
    set_w_all(1);
    set_g_all(1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst_hold%0d_c1", i), C1, 32'd0);
      check($sformatf("rst_hold%0d_c2", i), C2, 32'd0);
    end
    Rst_n = 1'b0;
    // Constant input refills one tap per edge: 5*j after j edges, then 45.
    for (int j = 1; j <= 11; j++) begin
      tick();
      check($sformatf("rst_fill%0d_c1", j), C1, 32'(5 * ((j > 9) ? 9 : j)));
      check($sformatf("rst_fill%0d_c2", j), C2, 32'(5 * ((j > 9) ? 9 : j)));
    end
    flush("rst");

    // Skewed 3s, W=1, G=2.
    set_w_all(1);
    set_g_all(2);
    for (int k = 0; k < 9; k++) vec[k] = 3;
    run_skew("skew3", 32'd27, 32'd54);

    // Impulse on tap 5 only.
    set_w_all(1);
    set_g_all(1);
    w[4] = 7;
    g[4] = -3;
    for (int k = 0; k < 9; k++) vec[k] = 0;
    vec[4] = 10;
    run_skew("impulse", 32'd70, -32'sd30);

    // Signed data.
    set_w_all(3);
    set_g_all(-1);
    for (int k = 0; k < 9; k++) vec[k] = -2;
    run_skew("signed", -32'sd54, 32'd18);

    // Modular wrap on tap 1.
    set_w_all(0);
    set_g_all(0);
    w[0] = 2;
    for (int k = 0; k < 9; k++) vec[k] = 0;
    vec[0] = 32'sh4000_0000;
    run_skew("wrap_x2", 32'h8000_0000, 32'd0);
    w[0] = 4;
    vec[0] = 32'sh4000_0000;
    g[0] = 2;
    run_skew("wrap_x4", 32'd0, 32'h8000_0000);
    flush("wrap");

    // Steady stream, then a one-edge reset pulse.
    set_w_all(1);
    set_g_all(1);
    set_f_all(4);
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 9 || j == 12) begin
        check($sformatf("stream_full%0d_c1", j), C1, 32'd36);
        check($sformatf("stream_full%0d_c2", j), C2, 32'd36);
      end
    end
    Rst_n = 1'b1;
    tick();
    check("stream_rst_c1", C1, 32'd0);
    check("stream_rst_c2", C2, 32'd0);
    Rst_n = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j == 1 || j == 8 || j == 9 || j == 10) begin
        check($sformatf("stream_refill%0d_c1", j), C1, 32'(4 * ((j > 9) ? 9 : j)));
        check($sformatf("stream_refill%0d_c2", j), C2, 32'(4 * ((j > 9) ? 9 : j)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_conv_fixew

// File: doc/conv_fixew.md
Name: conv_fixew

Overview:
- 9-tap, two-output-channel systolic convolution engine for signed fixed-point (integer) data.
- Nine feature inputs F1..F9 enter a chain of 9 multiply-accumulate cells; each cell adds its product to the partial sum from the previous cell.
- The upstream feature buffer applies a one-cycle-per-tap skew to the inputs.
- Two independent weight sets (W, G) share the feature stream and produce two output channels, C1 and C2, one result per clock.

Parameters:
- N, 32, data, weight and accumulator width in bits (two's complement).

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  synchronous, active-high reset (1 = reset), despite the name.
- F1..F9  in  N each  signed feature tap k = 1..9, pre-skewed by the caller.
- W00,W01,W02,W03,W10,W11,W12,W13,W14  in  N each  signed channel-1 weights for taps 1..9, in the listed order.
- G00,G01,G02,G03,G10,G11,G12,G13,G14  in  N each  signed channel-2 weights for taps 1..9, in the same order.
- C1  out  N  signed channel-1 result, registered.
- C2  out  N  signed channel-2 result, registered.

Behaviour:
- Free-running pipeline. No valid or ready handshake. A new sample is accepted on every rising edge.
- Weights are sampled combinationally each cycle; the caller holds them stable during a convolution.
- Per channel, nine registers P1..P9 form the chain:
  - P1 <= F1*w1
  - Pk <= P(k-1) + Fk*wk, for k = 2..9
  - C = P9
  - w is W for C1 and G for C2.
- Closed form: the value of C1 after edge n equals the sum over k = 1..9 of wk * Fk, with Fk sampled at edge n-9+k. C2 uses the same formula with G.
- Timing for a skewed vector: tap k is presented at edge e+k-1. The complete sum is visible on C after edge e+8 (9-cycle fill latency).
- Arithmetic: signed multiply and add, with each product and sum truncated to the low N bits (modular wrap). No saturation and no rounding.
- Reset: while Rst_n = 1 at a rising edge, all P registers of both channels and C1/C2 are cleared to 0.
- Reset asserted mid-stream flushes all partial sums. After release, outputs reflect only post-reset inputs; the chain refills over 9 cycles, with pre-reset taps contributing 0.
- All-zero inputs hold C1 = C2 = 0.

Decomposition:
- Shared package: the data width constant (default 32) and the tap count constant TAPS = 9.
- One sub-module, conv_pe:
  - Inputs: feature, weight, partial-sum-in.
  - Output: registered partial-sum-out, equal to psum_in + f*w, truncated to N bits.
  - Synchronous active-high clear.
- Top level instantiates 2 x 9 conv_pe cells. Cell 1 of each chain has psum_in tied to 0.

Test Plan:
- Reset with inputs F = 5 and all weights 1, reset held 2 cycles: C1 = C2 = 0 throughout reset. The first nonzero output appears only after the chain refills with post-reset data.
- Skewed vector with F = 3 on all taps (tap k driven only at edge e+k-1, 0 otherwise), all W = 1, all G = 2: C1 = 27 and C2 = 54 exactly after edge e+8; both are 0 in the cycles immediately before and after.
- Impulse with only F5 = 10 for one edge e, W10 = 7, G10 = -3, other weights 1: C1 = 70 and C2 = -30 after edge e+4 for one cycle; 0 otherwise.
- Signed data, skewed vector with all F = -2, all W = 3, all G = -1: C1 = -54, C2 = 18.
- Wrap:
  - F1 = 0x4000_0000, W00 = 2, other weights and inputs 0: C1 = 0x8000_0000 (-2^31) after edge e+8.
  - F1 = 0x4000_0000, W00 = 4: C1 = 0.
- Steady stream with all Fk held at 4, all W = 1, all G = 1, then reset pulsed for 1 cycle:
  - C1 = C2 = 36 every cycle once full.
  - The reset cycle zeroes the outputs; after release the outputs return to 36 once the chain refills.
